// File: rtl/decode_ctrl_seq.sv
// decode_ctrl_seq: registered RV32I/Zicsr/MRET decoder and control sequencer.
// Define DECODE_M_EXT_EN to enable M-extension decode and the multi-cycle MDU wait path.
module decode_ctrl_seq #(
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    input  logic               flush,
    output logic               stall_o,
    output logic               ctrl_valid,
    output logic               illegal_instr,
    output logic               rf_write,
    output logic               use_imm,
    output logic               csr_rd,
    output logic               csr_wr,
    output logic               is_mret,
    output logic [2:0]         extend_sel,
    output logic [2:0]         br_type,
    output logic [1:0]         sel_pc,
    output logic [1:0]         wdata_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mdu_start,
    output logic [2:0]         mdu_op,
    output logic               mdu_abort
);

`ifdef DECODE_M_EXT_EN
    localparam bit MExtEn = 1'b1;
`else
    localparam bit MExtEn = 1'b0;
`endif

    localparam int unsigned MaxLat = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AluXor  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] AluSltu = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] AluSrl  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] AluSra  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] AluMul  = ALUOP_W'(10);

    typedef struct packed {
        logic               illegal;
        logic               rf_write;
        logic               use_imm;
        logic               csr_rd;
        logic               csr_wr;
        logic               is_mret;
        logic [2:0]         extend_sel;
        logic [2:0]         br_type;
        logic [1:0]         sel_pc;
        logic [1:0]         wdata_sel;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    logic [6:0] opcode;
    logic [6:0] func7;
    logic [2:0] func3;
    ctrl_t      dec;
    logic       dec_is_m;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Shared func3 -> ALU op map for R-type and I-type; callers override sub/sra.
    function automatic logic [ALUOP_W-1:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = AluAdd;
            3'b001:  base_alu = AluSll;
            3'b010:  base_alu = AluSlt;
            3'b011:  base_alu = AluSltu;
            3'b100:  base_alu = AluXor;
            3'b101:  base_alu = AluSrl;
            3'b110:  base_alu = AluOr;
            default: base_alu = AluAnd;
        endcase
    endfunction

    always_comb begin
        dec      = '0;
        dec_is_m = 1'b0;
        case (opcode)
            OpReg: begin
                dec.rf_write = 1'b1;
                if (func7 == 7'h00) begin
                    dec.alu_op = base_alu(func3);
                end else if (func7 == 7'h20 && func3 == 3'b000) begin
                    dec.alu_op = AluSub;
                end else if (func7 == 7'h20 && func3 == 3'b101) begin
                    dec.alu_op = AluSra;
                end else if (MExtEn && func7 == 7'h01) begin
                    dec_is_m   = 1'b1;
                    dec.alu_op = AluMul + ALUOP_W'(func3);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OpImm: begin
                dec.rf_write = 1'b1;
                dec.use_imm  = 1'b1;
                dec.alu_op   = base_alu(func3);
                if (func3 == 3'b001 || func3 == 3'b101) begin
                    dec.extend_sel = 3'd2;
                    if (func3 == 3'b101 && func7 == 7'h20) begin
                        dec.alu_op = AluSra;
                    end else if (func7 != 7'h00) begin
                        dec.illegal = 1'b1;
                    end
                end
            end
            OpLoad: begin
                dec.rf_write  = 1'b1;
                dec.use_imm   = 1'b1;
                dec.wdata_sel = 2'd1;
            end
            OpStore: begin
                dec.use_imm    = 1'b1;
                dec.extend_sel = 3'd1;
            end
            OpLui, OpAuipc: begin
                dec.rf_write   = 1'b1;
                dec.use_imm    = 1'b1;
                dec.extend_sel = 3'd3;
                dec.sel_pc     = (opcode == OpLui) ? 2'd2 : 2'd1;
            end
            OpJal, OpJalr: begin
                dec.rf_write   = 1'b1;
                dec.use_imm    = 1'b1;
                dec.br_type    = 3'd7;
                dec.wdata_sel  = 2'd2;
                dec.extend_sel = (opcode == OpJal) ? 3'd5 : 3'd0;
                dec.sel_pc     = (opcode == OpJal) ? 2'd1 : 2'd0;
            end
            OpBranch: begin
                dec.use_imm    = 1'b1;
                dec.extend_sel = 3'd4;
                dec.sel_pc     = 2'd1;
                case (func3)
                    3'b000:  dec.br_type = 3'd1;
                    3'b001:  dec.br_type = 3'd2;
                    3'b100:  dec.br_type = 3'd3;
                    3'b101:  dec.br_type = 3'd4;
                    3'b110:  dec.br_type = 3'd5;
                    3'b111:  dec.br_type = 3'd6;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OpSystem: begin
                if (func3 == 3'b000) begin
                    dec.is_mret = 1'b1;
                end else if (func3 == 3'b100) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.rf_write  = 1'b1;
                    dec.csr_rd    = 1'b1;
                    dec.csr_wr    = 1'b1;
                    dec.wdata_sel = 2'd3;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.rf_write = 1'b0;
            dec.csr_wr   = 1'b0;
            dec.br_type  = 3'd0;
        end
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            valid_q, valid_d;
    logic            stall_q, stall_d;
    logic            start_q, start_d;
    logic            abort_q, abort_d;
    logic [2:0]      mdu_op_q, mdu_op_d;
    logic            accept;

    assign accept = instr_valid && !stall_q && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        mdu_op_d = mdu_op_q;
        valid_d  = 1'b0;
        stall_d  = 1'b0;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    ctrl_d = dec;
                    if (dec_is_m) begin
                        state_d  = StWait;
                        cnt_d    = func3[2] ? CntW'(DIV_LAT - 1) : CntW'(MUL_LAT - 1);
                        start_d  = 1'b1;
                        stall_d  = 1'b1;
                        mdu_op_d = func3;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    // Stall stays high through the ctrl_valid cycle so fetch holds one more beat.
                    state_d = StIdle;
                    valid_d = 1'b1;
                    stall_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CntW'(1);
                    stall_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            mdu_op_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            mdu_op_q <= mdu_op_d;
        end
    end

    assign stall_o       = stall_q;
    assign ctrl_valid    = valid_q;
    assign illegal_instr = ctrl_q.illegal;
    assign rf_write      = ctrl_q.rf_write;
    assign use_imm       = ctrl_q.use_imm;
    assign csr_rd        = ctrl_q.csr_rd;
    assign csr_wr        = ctrl_q.csr_wr;
    assign is_mret       = ctrl_q.is_mret;
    assign extend_sel    = ctrl_q.extend_sel;
    assign br_type       = ctrl_q.br_type;
    assign sel_pc        = ctrl_q.sel_pc;
    assign wdata_sel     = ctrl_q.wdata_sel;
    assign alu_op        = ctrl_q.alu_op;
    assign mdu_start     = start_q;
    assign mdu_op        = mdu_op_q;
    assign mdu_abort     = abort_q;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// Self-checking bench for decode_ctrl_seq: directed cases plus a randomized stream
// checked against a cycle-arithmetic reference model.
module tb_decode_ctrl_seq;

`ifdef DECODE_M_EXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif
    localparam int MUL_L = 2;
    localparam int DIV_L = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        flush;
    logic        stall_o, ctrl_valid, illegal_instr, rf_write, use_imm;
    logic        csr_rd, csr_wr, is_mret, mdu_start, mdu_abort;
    logic [2:0]  extend_sel, br_type, mdu_op;
    logic [1:0]  sel_pc, wdata_sel;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_ctrl_seq #(.ALUOP_W(5), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .flush(flush),
        .stall_o(stall_o), .ctrl_valid(ctrl_valid), .illegal_instr(illegal_instr),
        .rf_write(rf_write), .use_imm(use_imm), .csr_rd(csr_rd), .csr_wr(csr_wr),
        .is_mret(is_mret), .extend_sel(extend_sel), .br_type(br_type), .sel_pc(sel_pc),
        .wdata_sel(wdata_sel), .alu_op(alu_op), .mdu_start(mdu_start), .mdu_op(mdu_op),
        .mdu_abort(mdu_abort)
    );

    typedef struct packed {
        logic       ill, rfw, imm, crd, cwr, mret, sys, chk_rfw, chk_imm;
        logic [2:0] ext, br;
        logic [1:0] selpc, wsel;
        logic [4:0] alu;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        flush = 1'b0;
        instr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference decode written from the instruction-set tables.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [4:0] atab [8];
        logic [2:0] btab [8];
        logic [2:0] f3;
        logic [6:0] f7;
        atab = '{5'd0, 5'd7, 5'd5, 5'd6, 5'd3, 5'd8, 5'd2, 5'd4};
        btab = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.chk_rfw = 1'b1;
        e.chk_imm = 1'b1;
        case (w[6:0])
            7'h33: begin
                e.rfw = 1'b1;
                if (f7 == 7'h00) e.alu = atab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd9;
                else if (f7 == 7'h01 && MEXT) e.alu = 5'd10 + {2'b00, f3};
                else e.ill = 1'b1;
            end
            7'h13: begin
                e.rfw = 1'b1; e.imm = 1'b1; e.alu = atab[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.ext = 3'd2;
                    if (f3 == 3'd5 && f7 == 7'h20) e.alu = 5'd9;
                    else if (f7 != 7'h00) e.ill = 1'b1;
                end
            end
            7'h03: begin e.rfw = 1'b1; e.imm = 1'b1; e.wsel = 2'd1; end
            7'h23: begin e.imm = 1'b1; e.ext = 3'd1; end
            7'h37: begin e.rfw = 1'b1; e.imm = 1'b1; e.ext = 3'd3; e.selpc = 2'd2; end
            7'h17: begin e.rfw = 1'b1; e.imm = 1'b1; e.ext = 3'd3; e.selpc = 2'd1; end
            7'h6f: begin
                e.rfw = 1'b1; e.imm = 1'b1; e.ext = 3'd5; e.selpc = 2'd1;
                e.br = 3'd7; e.wsel = 2'd2;
            end
            7'h67: begin e.rfw = 1'b1; e.imm = 1'b1; e.br = 3'd7; e.wsel = 2'd2; end
            7'h63: begin
                e.ext = 3'd4; e.selpc = 2'd1; e.chk_imm = 1'b0; e.br = btab[f3];
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
            end
            7'h73: begin
                e.sys = 1'b1;
                if (f3 == 3'd0) e.mret = 1'b1;
                else if (f3 == 3'd4) e.ill = 1'b1;
                else begin e.crd = 1'b1; e.cwr = 1'b1; e.wsel = 2'd3; e.chk_rfw = 1'b0; end
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin e.rfw = 1'b0; e.cwr = 1'b0; e.br = 3'd0; end
        return e;
    endfunction

    function automatic bit is_m(input logic [31:0] w);
        return MEXT && w[6:0] == 7'h33 && w[31:25] == 7'h01;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  ops [11];
        logic [6:0]  f7s [4];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h73, 7'h00};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h5a};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 10)];
        if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
        if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
        return w;
    endfunction

    task automatic chk_bundle(input exp_t e);
        chk("illegal_instr", illegal_instr, e.ill);
        chk("csr_wr", csr_wr, e.cwr);
        chk("br_type", br_type, e.br);
        if (e.chk_rfw) chk("rf_write", rf_write, e.rfw);
        if (!e.ill) begin
            chk("is_mret", is_mret, e.mret);
            chk("csr_rd", csr_rd, e.crd);
            if (e.sys) begin
                if (e.crd) chk("wdata_sel", wdata_sel, e.wsel);
            end else begin
                chk("extend_sel", extend_sel, e.ext);
                chk("sel_pc", sel_pc, e.selpc);
                chk("wdata_sel", wdata_sel, e.wsel);
                chk("alu_op", alu_op, e.alu);
                if (e.chk_imm) chk("use_imm", use_imm, e.imm);
            end
        end
    endtask

    initial begin
        exp_t       eb, mb, nb;
        logic       exp_stall, nv, ns, na, nst, acc;
        logic [2:0] exp_op;
        bit         pend, saw;
        int         n, due;

        // Reset: every output low.
        rst_n = 1'b0; instr_valid = 1'b0; flush = 1'b0; instr = '0;
        #2;
        chk("rst_ctrl_valid", ctrl_valid, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_bundle", {illegal_instr, rf_write, use_imm, csr_rd, csr_wr, is_mret}, 0);
        chk("rst_fields", {extend_sel, br_type, sel_pc, wdata_sel, alu_op}, 0);
        chk("rst_mdu", {mdu_start, mdu_op, mdu_abort}, 0);
        do_reset();

        instr_valid = 1'b1; instr = 32'h002081B3;   // add
        step();
        chk("add_valid", ctrl_valid, 1);
        chk("add_alu", alu_op, 0);
        chk("add_rfw", rf_write, 1);
        chk("add_imm", use_imm, 0);
        instr = 32'h40335293;                       // srai
        step();
        chk("srai_valid", ctrl_valid, 1);
        chk("srai_alu", alu_op, 9);
        chk("srai_ext", extend_sel, 2);
        chk("srai_imm", use_imm, 1);
        instr = 32'h00208463;                       // beq
        step();
        chk("beq_br", br_type, 1);
        chk("beq_ext", extend_sel, 4);
        chk("beq_selpc", sel_pc, 1);
        chk("beq_rfw", rf_write, 0);
        instr = 32'hFFFFFFFF;
        step();
        chk("ill_flag", illegal_instr, 1);
        chk("ill_rfw", rf_write, 0);
        instr = 32'h30200073;                       // mret
        step();
        chk("mret_flag", is_mret, 1);
        chk("mret_cwr", csr_wr, 0);
        instr = 32'h002081B3; flush = 1'b1;
        step();
        chk("flush_kills", ctrl_valid, 0);
        flush = 1'b0; instr_valid = 1'b0;
        step();
        chk("idle_no_valid", ctrl_valid, 0);

`ifdef DECODE_M_EXT_EN
        instr_valid = 1'b1; instr = 32'h022081B3;   // mul
        step();
        instr_valid = 1'b0;
        chk("mul_start", mdu_start, 1);
        chk("mul_op", mdu_op, 0);
        chk("mul_stall1", stall_o, 1);
        chk("mul_novalid1", ctrl_valid, 0);
        step();
        chk("mul_stall2", stall_o, 1);
        chk("mul_start_pulse", mdu_start, 0);
        chk("mul_novalid2", ctrl_valid, 0);
        step();
        chk("mul_stall3", stall_o, 1);
        chk("mul_valid", ctrl_valid, 1);
        chk("mul_alu", alu_op, 10);
        chk("mul_rfw", rf_write, 1);
        step();
        chk("mul_stall_drop", stall_o, 0);
        chk("mul_valid_pulse", ctrl_valid, 0);

        instr_valid = 1'b1; instr = 32'h0220C1B3;   // div
        step();
        instr_valid = 1'b0;
        chk("div_op", mdu_op, 4);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("div_abort", mdu_abort, 1);
        chk("div_stall_clear", stall_o, 0);
        chk("div_abort_novalid", ctrl_valid, 0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ctrl_valid || mdu_abort) saw = 1'b1;
        end
        chk("div_no_bundle", saw, 0);

        instr_valid = 1'b1; instr = 32'h0220C1B3;
        step();
        instr_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait_stall", stall_o, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_mid_wait_abort", mdu_abort, 0);
        chk("rst_mid_wait_idle", stall_o, 0);
`else
        instr_valid = 1'b1; instr = 32'h022081B3;   // mul without M support
        step();
        instr_valid = 1'b0;
        chk("nom_illegal", illegal_instr, 1);
        chk("nom_valid", ctrl_valid, 1);
        chk("nom_stall", stall_o, 0);
        chk("nom_start", mdu_start, 0);
        step();
        chk("nom_stall_after", stall_o, 0);
`endif

        // Randomized stream against the timing model.
        do_reset();
        exp_stall = 1'b0; exp_op = 3'd0; pend = 1'b0; n = 0; due = 0;
        mb = '0; nb = '0;
        for (int i = 0; i < 1500; i++) begin
            instr = gen_instr();
            instr_valid = ($urandom_range(0, 9) < 8);
            flush = ($urandom_range(0, 15) == 0);
            nv = 1'b0; ns = 1'b0; na = 1'b0; nst = 1'b0;
            acc = instr_valid && !exp_stall && !flush;
            if (pend && n < due) begin
                if (flush) begin
                    na = 1'b1;
                    pend = 1'b0;
                end else begin
                    nst = 1'b1;
                    if (n + 1 == due) begin nv = 1'b1; nb = mb; end
                end
            end else if (pend) begin
                pend = 1'b0;
            end
            if (acc) begin
                eb = ref_decode(instr);
                if (is_m(instr)) begin
                    pend = 1'b1;
                    due = n + 1 + (instr[14] ? DIV_L : MUL_L);
                    ns = 1'b1; nst = 1'b1;
                    exp_op = instr[14:12];
                    mb = eb;
                end else begin
                    nv = 1'b1; nb = eb;
                end
            end
            step();
            n++;
            exp_stall = nst;
            chk("rnd_ctrl_valid", ctrl_valid, nv);
            chk("rnd_stall", stall_o, nst);
            chk("rnd_mdu_start", mdu_start, ns);
            chk("rnd_mdu_abort", mdu_abort, na);
            chk("rnd_mdu_op", mdu_op, exp_op);
            if (nv) chk_bundle(nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_seq.md
# decode_ctrl_seq

Registered, parametrised instruction decoder and control sequencer for the RV32I pipeline, sitting between the fetch/decode register and the execute stage. It decodes RV32I plus Zicsr/MRET into a registered control bundle with a valid bit, flags illegal encodings, and handles flush. It optionally supports the M extension: it sequences multi-cycle multiply/divide operations through a small FSM and stalls fetch until the result is due.

## Interface
- `ALUOP_W`, 5: width of `alu_op`; must be ≥5.
- `MUL_LAT`, 2: cycles from MDU start to multiply result; must be ≥1.
- `DIV_LAT`, 33: cycles from MDU start to divide/remainder result; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: `instr` holds a valid instruction.
- `instr` in 32: instruction word.
- `flush` in 1: kill the decoded slot and any MDU operation in flight.
- `stall_o` out 1: fetch/decode must hold `instr`; instruction not accepted.
- `ctrl_valid` out 1: control bundle is valid this cycle.
- `illegal_instr` out 1: decoded instruction is illegal; qualified by `ctrl_valid`.
- `rf_write`, `use_imm`, `csr_rd`, `csr_wr`, `is_mret` out 1 each: execute controls.
- `extend_sel` out 3, `br_type` out 3, `sel_pc` out 2, `wdata_sel` out 2: execute controls.
- `alu_op` out `ALUOP_W`: ALU/MDU operation code.
- `mdu_start` out 1: one-cycle pulse that launches the MDU.
- `mdu_op` out 3: func3 of the M instruction; valid with `mdu_start`.
- `mdu_abort` out 1: one-cycle pulse that cancels the MDU.

## Operation
- Acceptance: the block accepts `instr` when `instr_valid && !stall_o && !flush`.
- Control encodings:
  - `extend_sel`: I=0, S=1, shamt=2, U=3, B=4, J=5.
  - `br_type`: none=0, beq=1, bne=2, blt=3, bge=4, bltu=5, bgeu=6, jump=7.
  - `sel_pc`: rs1=0, pc=1, zero=2.
  - `wdata_sel`: alu=0, mem=1, pc+4=2, csr=3.
- `alu_op` encoding: add=0, sub=1, or=2, xor=3, and=4, slt=5, sltu=6, sll=7, srl=8, sra=9, M ops=10+func3 (mul=10 … remu=17).
- SUB is only for R-type with func7=0x20; ADDI ignores func7.
- SLTI/SLTIU decode to 5/6.
- SLLI/SRLI/SRAI set `extend_sel`=2 and decode func7 from `instr[31:25]`.
- Loads, stores, AUIPC, LUI, JAL, JALR and branches all use `alu_op`=0.
- Illegal encodings:
  - unknown opcode;
  - branch func3 010 or 011;
  - R-type func7 outside {0x00, 0x20};
  - 0x20 with func3 ∉ {000, 101};
  - I-shift with a bad func7;
  - SYSTEM func3=100.
- On an illegal instruction, `illegal_instr`=1 and `rf_write`/`csr_wr`/`br_type` are forced to 0.
- SYSTEM func3=000 gives `is_mret`=1 with no writes; other SYSTEM func3 values give a CSR op (`csr_rd`=`csr_wr`=1, `wdata_sel`=3).
- FSM states:
  - IDLE:
    - Non-M accept → bundle registered, `ctrl_valid`=1 next cycle.
    - M accept → WAIT, `cnt` loaded with (func3[2] ? `DIV_LAT` : `MUL_LAT`)−1, `mdu_start`=1 next cycle, `ctrl_valid`=0.
  - WAIT:
    - `stall_o`=1.
    - `cnt` decrements each cycle.
    - When `cnt`==0: `ctrl_valid`=1 with the M bundle (`rf_write`=1, `wdata_sel`=0), then IDLE.
- Flush:
  - `ctrl_valid` is cleared next cycle.
  - In WAIT, flush causes a return to IDLE and pulses `mdu_abort` next cycle; no bundle is issued.
  - Flush wins over the final WAIT cycle.
- Reset:
  - All outputs 0, state IDLE, `cnt`=0; `stall_o`=0.
  - Reset asserted mid-WAIT returns to IDLE immediately, with no `mdu_abort`.

## Timing
- Non-M latency: 1 cycle from accept to `ctrl_valid`; throughput 1 per cycle.
- `mdu_start` rises the cycle after an M accept.
- `ctrl_valid` for an M op rises `LAT` cycles after `mdu_start`.
- `stall_o` is registered, high from the cycle after an M accept through the `ctrl_valid` cycle inclusive.
- `stall_o` drops the cycle after `ctrl_valid`; back-to-back M ops are then accepted.
- `ctrl_valid` is a single-cycle pulse per instruction; there is no backpressure from execute.

## Configuration
- `DECODE_M_EXT_EN`:
  - Defined: M decode, FSM WAIT path, `mdu_*` outputs active.
  - Undefined: func7=0x01 R-type is illegal, FSM is always IDLE, `stall_o`/`mdu_start`/`mdu_abort` are tied 0, `mdu_op`=0.

## Test plan
- Reset: hold `rst_n`=0 → every output 0. Then `instr`=0x002081B3 (add) → `ctrl_valid`=1 next cycle, `alu_op`=0, `rf_write`=1, `use_imm`=0.
- `instr`=0x40335293 (srai) → `alu_op`=9, `extend_sel`=2, `use_imm`=1. `instr`=0x00208463 (beq) → `br_type`=1, `extend_sel`=4, `sel_pc`=1, `rf_write`=0.
- `instr`=0xFFFFFFFF → `illegal_instr`=1, `rf_write`=0. `instr`=0x30200073 (mret) → `is_mret`=1, `csr_wr`=0.
- Macro defined, `instr`=0x022081B3 (mul), `MUL_LAT`=2:
  - `mdu_start`=1 with `mdu_op`=0 at cycle+1;
  - `stall_o`=1 for cycles +1..+3;
  - `ctrl_valid`=1, `alu_op`=10 at cycle+3.
- Macro defined, `instr`=0x0220C1B3 (div), `flush` asserted at 5 cycles after accept → `mdu_abort` pulse, no `ctrl_valid`, `stall_o`=0 the next cycle.
- Macro undefined, `instr`=0x022081B3 → `illegal_instr`=1, `stall_o` stays 0.
